// File: rtl/csa_accumulator_if.sv
// Operand stream in, frame result out: the handshake bundle around csa_accumulator.
interface csa_accumulator_if #(
  parameter int WIDTH   = 4,
  parameter int MAX_OPS = 16
);
  localparam int ACC_W = WIDTH + $clog2(MAX_OPS);
  localparam int CW    = $clog2(MAX_OPS) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CW-1:0]    out_count;
  logic             forced_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, forced_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, forced_last
  );
endinterface

// File: rtl/csa_accumulator.sv
// Frame accumulator: carry-save adds operands each cycle, then resolves S+C
// with a CHUNK-bit carry-propagate slice per cycle before presenting the sum.
module csa_accumulator #(
  parameter int WIDTH   = 4,
  parameter int MAX_OPS = 16,
  parameter int CHUNK   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  csa_accumulator_if.slave bus
);
  localparam int ACC_W = WIDTH + $clog2(MAX_OPS);
  localparam int NCH   = (ACC_W + CHUNK - 1) / CHUNK;
  localparam int CW    = $clog2(MAX_OPS) + 1;
  localparam int IW    = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic             r_armed;
  logic [ACC_W-1:0] r_s;
  logic [ACC_W-1:0] r_c;
  logic [ACC_W-1:0] r_sum;
  logic [CW-1:0]    r_count;
  logic             r_carry;
  logic             r_forced;
  logic [IW-1:0]    r_chunkIdx;

  logic             w_accept;
  logic             w_close;
  logic             w_lastChunk;
  logic [ACC_W-1:0] w_x;
  logic [ACC_W-1:0] w_sumNext;
  logic [CW-1:0]    w_countNext;
  logic [CHUNK-1:0] w_sSlice;
  logic [CHUNK-1:0] w_cSlice;
  logic [CHUNK:0]   w_chunkSum;

  // r_armed keeps in_ready low until the first clock edge after reset releases
  assign bus.in_ready    = r_armed && ((r_state == IDLE) || (r_state == ACCUM));
  assign bus.out_valid   = (r_state == DONE);
  assign bus.out_sum     = r_sum;
  assign bus.out_count   = r_count;
  assign bus.forced_last = r_forced;

  assign w_accept    = bus.in_valid && bus.in_ready;
  assign w_x         = ACC_W'(bus.in_data);
  assign w_countNext = (r_state == IDLE) ? CW'(1) : r_count + CW'(1);
  assign w_close     = bus.in_last || (w_countNext == CW'(MAX_OPS));
  assign w_lastChunk = (r_chunkIdx == IW'(NCH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE, ACCUM: if (w_accept) w_nextState = w_close ? RESOLVE : ACCUM;
      RESOLVE:     if (w_lastChunk) w_nextState = DONE;
      DONE:        if (bus.out_ready) w_nextState = IDLE;
      default:     w_nextState = IDLE;
    endcase
  end

  // Select the current chunk of S and C; bits past ACC_W read as zero
  always_comb begin
    w_sSlice = '0;
    w_cSlice = '0;
    for (int b = 0; b < ACC_W; b++) begin
      if ((b / CHUNK) == int'(r_chunkIdx)) begin
        w_sSlice[b % CHUNK] = r_s[b];
        w_cSlice[b % CHUNK] = r_c[b];
      end
    end
    w_chunkSum = {1'b0, w_sSlice} + {1'b0, w_cSlice} + {{CHUNK{1'b0}}, r_carry};
    w_sumNext  = r_sum;
    for (int b = 0; b < ACC_W; b++) begin
      if ((b / CHUNK) == int'(r_chunkIdx)) w_sumNext[b] = w_chunkSum[b % CHUNK];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed    <= 1'b0;
      r_s        <= '0;
      r_c        <= '0;
      r_sum      <= '0;
      r_count    <= '0;
      r_carry    <= 1'b0;
      r_forced   <= 1'b0;
      r_chunkIdx <= '0;
    end else begin
      r_armed <= 1'b1;
      case (r_state)
        IDLE, ACCUM: begin
          if (w_accept) begin
            if (r_state == IDLE) begin
              r_s <= w_x;
              r_c <= '0;
            end else begin
              r_s <= r_s ^ r_c ^ w_x;
              r_c <= ((r_s & r_c) | (r_s & w_x) | (r_c & w_x)) << 1;
            end
            r_count    <= w_countNext;
            r_carry    <= 1'b0;
            r_chunkIdx <= '0;
            if (w_close) r_forced <= ~bus.in_last;
          end
        end
        RESOLVE: begin
          r_sum      <= w_sumNext;
          r_carry    <= w_chunkSum[CHUNK];
          r_chunkIdx <= w_lastChunk ? '0 : r_chunkIdx + IW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_csa_accumulator.sv
// Directed bench for csa_accumulator: default 4-bit/4-chunk instance plus a
// 5-bit/3-chunk instance for uneven chunking.
module tb_csa_accumulator;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  csa_accumulator_if #(.WIDTH(4), .MAX_OPS(16)) busA ();
  csa_accumulator_if #(.WIDTH(5), .MAX_OPS(16)) busB ();

  csa_accumulator #(.WIDTH(4), .MAX_OPS(16), .CHUNK(4)) dutA (
    .clk(clk), .rst_n(rst_n), .bus(busA.slave)
  );
  csa_accumulator #(.WIDTH(5), .MAX_OPS(16), .CHUNK(3)) dutB (
    .clk(clk), .rst_n(rst_n), .bus(busB.slave)
  );

  task automatic sendA(input logic [3:0] d, input logic last);
    busA.in_valid = 1'b1;
    busA.in_data  = d;
    busA.in_last  = last;
    @(posedge clk); @(negedge clk);
    busA.in_valid = 1'b0;
    busA.in_last  = 1'b0;
  endtask

  task automatic sendB(input logic [4:0] d, input logic last);
    busB.in_valid = 1'b1;
    busB.in_data  = d;
    busB.in_last  = last;
    @(posedge clk); @(negedge clk);
    busB.in_valid = 1'b0;
    busB.in_last  = 1'b0;
  endtask

  task automatic waitValidA(output int n);
    n = 0;
    while (busA.out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); @(negedge clk); n++;
    end
    if (busA.out_valid !== 1'b1) n = -1;
  endtask

  task automatic waitValidB(output int n);
    n = 0;
    while (busB.out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); @(negedge clk); n++;
    end
    if (busB.out_valid !== 1'b1) n = -1;
  endtask

  task automatic releaseA;
    busA.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    busA.out_ready = 1'b0;
  endtask

  task automatic releaseB;
    busB.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    busB.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    logic [14:0] got;
    busA.in_valid = 1'b0; busA.in_data = '0; busA.in_last = 1'b0; busA.out_ready = 1'b0;
    busB.in_valid = 1'b0; busB.in_data = '0; busB.in_last = 1'b0; busB.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    got = {busA.in_ready, busA.out_valid, busA.out_sum, busA.out_count};
    checks++;
    if (got !== 15'h0 || busA.forced_last !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%h forced=%b exp=0", got, busA.forced_last);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (busA.in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ready_before_edge got=%b exp=0", busA.in_ready);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (busA.in_ready !== 1'b1 || busB.in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ready_after_edge got=%b%b exp=11", busA.in_ready, busB.in_ready);
    end
  endtask

  task automatic test_three_f;
    logic [13:0] got;
    sendA(4'hF, 1'b0);
    sendA(4'hF, 1'b0);
    busA.in_valid = 1'b1; busA.in_data = 4'hF; busA.in_last = 1'b1;
    @(posedge clk); @(negedge clk);
    busA.in_valid = 1'b0; busA.in_last = 1'b0;
    checks++;
    if (busA.out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL latency_edge1 got=%b exp=0", busA.out_valid);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (busA.out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL latency_edge2 got=%b exp=0", busA.out_valid);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (busA.out_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL latency_edge3 got=%b exp=1", busA.out_valid);
    end
    got = {busA.out_sum, busA.out_count, busA.forced_last};
    checks++;
    if (got !== {8'h2D, 5'd3, 1'b0} || busA.in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL three_f_result got=%h ready=%b exp=%h ready=0", got, busA.in_ready,
               {8'h2D, 5'd3, 1'b0});
    end
    releaseA;
    checks++;
    if (busA.out_valid !== 1'b0 || busA.in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL three_f_release got=%b%b exp=01", busA.out_valid, busA.in_ready);
    end
  endtask

  task automatic test_max_ops;
    logic [13:0] got;
    int n;
    for (int i = 0; i < 16; i++) begin
      sendA(4'hF, 1'b0);
      if (i == 14) begin
        checks++;
        if (busA.in_ready !== 1'b1) begin
          failures++;
          $display("[TB] FAIL max_ready_15 got=%b exp=1", busA.in_ready);
        end
      end
    end
    checks++;
    if (busA.in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL max_ready_16 got=%b exp=0", busA.in_ready);
    end
    waitValidA(n);
    checks++;
    if (n != 2) begin
      failures++;
      $display("[TB] FAIL max_latency got=%0d exp=2", n);
    end
    got = {busA.out_sum, busA.out_count, busA.forced_last};
    checks++;
    if (got !== {8'hF0, 5'd16, 1'b1}) begin
      failures++;
      $display("[TB] FAIL max_result got=%h exp=%h", got, {8'hF0, 5'd16, 1'b1});
    end
    releaseA;
  endtask

  task automatic test_single;
    logic [13:0] got;
    int n;
    sendA(4'h9, 1'b1);
    waitValidA(n);
    got = {busA.out_sum, busA.out_count, busA.forced_last};
    checks++;
    if (n != 2 || got !== {8'h09, 5'd1, 1'b0}) begin
      failures++;
      $display("[TB] FAIL single_result got=%h lat=%0d exp=%h lat=2", got, n, {8'h09, 5'd1, 1'b0});
    end
    releaseA;
  endtask

  task automatic test_backpressure;
    logic [13:0] got;
    int n;
    sendA(4'h1, 1'b0);
    sendA(4'h2, 1'b0);
    sendA(4'h3, 1'b0);
    sendA(4'h4, 1'b1);
    waitValidA(n);
    for (int i = 0; i < 5; i++) begin
      busA.in_valid = 1'b1; busA.in_data = 4'h5; busA.in_last = 1'b1;
      @(posedge clk); @(negedge clk);
      got = {busA.out_sum, busA.out_count, busA.forced_last};
      checks++;
      if (got !== {8'h0A, 5'd4, 1'b0} || busA.out_valid !== 1'b1 || busA.in_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL hold_cycle%0d got=%h valid=%b ready=%b exp=%h valid=1 ready=0",
                 i, got, busA.out_valid, busA.in_ready, {8'h0A, 5'd4, 1'b0});
      end
    end
    busA.in_valid = 1'b0; busA.in_last = 1'b0;
    releaseA;
    checks++;
    if (busA.out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL hold_release got=%b exp=0", busA.out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [13:0] got;
    int n;
    busA.out_ready = 1'b1;
    sendA(4'h5, 1'b0);
    sendA(4'h6, 1'b1);
    waitValidA(n);
    got = {busA.out_sum, busA.out_count, busA.forced_last};
    checks++;
    if (n != 2 || got !== {8'h0B, 5'd2, 1'b0}) begin
      failures++;
      $display("[TB] FAIL next_frame got=%h lat=%0d exp=%h lat=2", got, n, {8'h0B, 5'd2, 1'b0});
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (busA.out_valid !== 1'b0 || busA.in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL next_frame_drop got=%b%b exp=01", busA.out_valid, busA.in_ready);
    end
    busA.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [14:0] got;
    logic seen;
    int n;
    sendA(4'h7, 1'b0);
    sendA(4'h3, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    got = {busA.in_ready, busA.out_valid, busA.out_sum, busA.out_count};
    checks++;
    if (got !== 15'h0 || busA.forced_last !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_outputs got=%h forced=%b exp=0", got, busA.forced_last);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); @(negedge clk);
      if (busA.out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_no_valid got=%b exp=0", seen);
    end
    sendA(4'h7, 1'b0);
    sendA(4'h1, 1'b1);
    waitValidA(n);
    checks++;
    if (n != 2 || busA.out_sum !== 8'h08 || busA.out_count !== 5'd2) begin
      failures++;
      $display("[TB] FAIL midreset_next got=%h/%0d lat=%0d exp=08/2 lat=2",
               busA.out_sum, busA.out_count, n);
    end
    releaseA;
  endtask

  task automatic test_chunk3;
    logic [14:0] got;
    logic [8:0]  refSum;
    logic [4:0]  d;
    int n;
    int len;
    for (int i = 0; i < 16; i++) sendB(5'h1F, 1'b0);
    waitValidB(n);
    got = {busB.out_sum, busB.out_count, busB.forced_last};
    checks++;
    if (n != 3 || got !== {9'h1F0, 5'd16, 1'b1}) begin
      failures++;
      $display("[TB] FAIL c3_max got=%h lat=%0d exp=%h lat=3", got, n, {9'h1F0, 5'd16, 1'b1});
    end
    releaseB;
    sendB(5'h1F, 1'b0);
    sendB(5'h01, 1'b1);
    waitValidB(n);
    checks++;
    if (n != 3 || busB.out_sum !== 9'h020) begin
      failures++;
      $display("[TB] FAIL c3_carry got=%h lat=%0d exp=020 lat=3", busB.out_sum, n);
    end
    releaseB;
    for (int f = 0; f < 4; f++) begin
      len = $urandom_range(1, 16);
      refSum = '0;
      for (int j = 0; j < len; j++) begin
        d = 5'($urandom_range(0, 31));
        refSum = refSum + 9'(d);
        sendB(d, (j == len - 1));
      end
      waitValidB(n);
      got = {busB.out_sum, busB.out_count, busB.forced_last};
      checks++;
      if (n != 3 || got !== {refSum, 5'(len), 1'b0}) begin
        failures++;
        $display("[TB] FAIL c3_frame%0d got=%h lat=%0d exp=%h lat=3", f, got, n,
                 {refSum, 5'(len), 1'b0});
      end
      releaseB;
    end
  endtask

  initial begin
    test_reset;
    test_three_f;
    test_max_ops;
    test_single;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    test_chunk3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
